// File: rtl/aes_pkg.sv
// Shared AES types, constants and the GF(2^8) xtime helper used by the
// InvMixColumns datapath.
package aes_pkg;

    typedef logic [7:0]  aes_byte_t;
    typedef logic [31:0] aes_col_t;

    localparam aes_byte_t GF_POLY  = 8'h1B;
    localparam int        AES_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } inv_mc_state_t;

    // Multiply by x in GF(2^8), reducing by the AES polynomial when bit 7 falls off.
    function automatic aes_byte_t xtime(input aes_byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mixcolumn_col.sv
// Combinational InvMixColumn for one 32-bit column; row 0 sits in the MSB byte.
module inv_mixcolumn_col
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    aes_byte_t w_a  [AES_COLS];
    aes_byte_t w_x2 [AES_COLS];
    aes_byte_t w_x4 [AES_COLS];
    aes_byte_t w_x8 [AES_COLS];
    aes_byte_t w_m9 [AES_COLS];
    aes_byte_t w_mb [AES_COLS];
    aes_byte_t w_md [AES_COLS];
    aes_byte_t w_me [AES_COLS];

    // Build the 09/0b/0d/0e multiples of every input byte from one xtime chain.
    always_comb begin
        for (int i = 0; i < AES_COLS; i++) begin
            w_a[i]  = i_col[31-8*i -: 8];
            w_x2[i] = xtime(w_a[i]);
            w_x4[i] = xtime(w_x2[i]);
            w_x8[i] = xtime(w_x4[i]);
            w_m9[i] = w_x8[i] ^ w_a[i];
            w_mb[i] = w_x8[i] ^ w_x2[i] ^ w_a[i];
            w_md[i] = w_x8[i] ^ w_x4[i] ^ w_a[i];
            w_me[i] = w_x8[i] ^ w_x4[i] ^ w_x2[i];
        end
    end

    // Each output row uses the circulant 0e,0b,0d,09 pattern rotated by its row index.
    always_comb begin
        o_col = '0;
        for (int r = 0; r < AES_COLS; r++) begin
            o_col[31-8*r -: 8] = w_me[r] ^ w_mb[(r+1)%AES_COLS]
                               ^ w_md[(r+2)%AES_COLS] ^ w_m9[(r+3)%AES_COLS];
        end
    end

endmodule

// File: rtl/aes_inv_mixcolumns_seq.sv
// Iterative AES InvMixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, then holds the result until taken.
module aes_inv_mixcolumns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    // The counter is only two bits, so a step of four wraps to zero by design.
    localparam logic [1:0] CNT_STEP   = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_GROUP = 2'(AES_COLS - COLS_PER_CYCLE);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_badParam
            $error("COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    inv_mc_state_t r_fsm;
    logic [127:0]  r_state;
    logic [1:0]    r_colCount;
    logic          r_inReady;
    logic          r_outValid;

    logic [31:0]   w_cols     [AES_COLS];
    logic [1:0]    w_grpIdx   [COLS_PER_CYCLE];
    logic [31:0]   w_grpIn    [COLS_PER_CYCLE];
    logic [31:0]   w_grpOut   [COLS_PER_CYCLE];
    logic [127:0]  w_nextState;

    // Split the working state into columns so the group mux can pick by index.
    always_comb begin
        for (int c = 0; c < AES_COLS; c++) begin
            w_cols[c] = r_state[127-32*c -: 32];
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign w_grpIdx[g] = r_colCount + 2'(g);
        assign w_grpIn[g]  = w_cols[w_grpIdx[g]];

        inv_mixcolumn_col u_invCol (
            .i_col (w_grpIn[g]),
            .o_col (w_grpOut[g])
        );
    end

    // Splice the freshly transformed column group back into the working state.
    always_comb begin
        w_nextState = r_state;
        for (int c = 0; c < AES_COLS; c++) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                if (w_grpIdx[g] == 2'(c)) begin
                    w_nextState[127-32*c -: 32] = w_grpOut[g];
                end
            end
        end
    end

    // Control FSM with registered handshake outputs; the state register only moves on capture and compute.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm      <= ST_IDLE;
            r_state    <= '0;
            r_colCount <= '0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid && r_inReady) begin
                        r_state    <= state_in;
                        r_colCount <= '0;
                        r_inReady  <= 1'b0;
                        r_fsm      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_state    <= w_nextState;
                    r_colCount <= r_colCount + CNT_STEP;
                    if (r_colCount == LAST_GROUP) begin
                        r_outValid <= 1'b1;
                        r_fsm      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_fsm      <= ST_IDLE;
                    end
                end
                default: begin
                    r_fsm      <= ST_IDLE;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign state_out = r_state;

endmodule

// File: tb/tb_aes_inv_mixcolumns_seq.sv
// Bench for the iterative InvMixColumns engine: three instances (1, 2 and 4
// columns per clock) share the same stimulus and are checked against a
// GF(2^8) matrix model, with literal vectors pinning that model.
module tb_aes_inv_mixcolumns_seq;

    localparam int NDUT = 3;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] state_in;

    logic         inReadyA  [NDUT];
    logic         outValidA [NDUT];
    logic [127:0] stateOutA [NDUT];

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;
    logic streamMode = 1'b0;

    logic         pending    [NDUT];
    logic         seenValid  [NDUT];
    logic         streamPrev [NDUT];
    logic [127:0] expVal     [NDUT];
    int           acceptEdge [NDUT];
    int           acceptCount[NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        aes_inv_mixcolumns_seq #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (in_valid),
            .in_ready  (inReadyA[g]),
            .state_in  (state_in),
            .out_valid (outValidA[g]),
            .out_ready (out_ready),
            .state_out (stateOutA[g])
        );
    end

    // Free-running clock and an edge counter used for latency and spacing checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int colsOf(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    function automatic int latOf(input int d);
        return 4 / colsOf(d);
    endfunction

    // Field multiply as a carry-less product followed by long division by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod ^= (16'(a) << i);
        end
        for (int k = 15; k >= 8; k--) begin
            if (prod[k]) prod ^= (16'h011B << (k - 8));
        end
        return prod[7:0];
    endfunction

    // Column times a circulant matrix whose first row is given by coefWord.
    function automatic logic [31:0] mixCol(input logic [31:0] col, input logic [31:0] coefWord);
        logic [31:0] res;
        logic [7:0]  acc;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) begin
                acc ^= gmul(col[31-8*j -: 8], coefWord[31-8*((j - r + 4) % 4) -: 8]);
            end
            res[31-8*r -: 8] = acc;
        end
        return res;
    endfunction

    function automatic logic [127:0] mixState(input logic [127:0] s, input logic [31:0] coefWord);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            res[127-32*c -: 32] = mixCol(s[127-32*c -: 32], coefWord);
        end
        return res;
    endfunction

    function automatic logic [127:0] invModel(input logic [127:0] s);
        return mixState(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] fwdModel(input logic [127:0] s);
        return mixState(s, 32'h02030101);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic allIdle();
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            if (!inReadyA[d] || outValidA[d]) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic waitIdle(input int bound);
        int n;
        n = 0;
        while (!allIdle() && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idle_reached", 128'(allIdle()), 128'(1));
    endtask

    // One-cycle offer of a state; callers make sure every instance is idle first.
    task automatic applyStimulus(input logic [127:0] s);
        state_in = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        state_in = 'x;
    endtask

    // Scoreboard: remembers what each instance accepted and checks results, latency and issue spacing.
    always @(negedge clk) begin
        if (!reset_n) begin
            for (int d = 0; d < NDUT; d++) begin
                pending[d]    = 1'b0;
                seenValid[d]  = 1'b0;
                streamPrev[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                if (outValidA[d]) begin
                    checkOutput($sformatf("d%0d_valid_has_txn", d), 128'(pending[d]), 128'(1));
                    if (!seenValid[d]) begin
                        checkOutput($sformatf("d%0d_latency", d), 128'(cyc - acceptEdge[d]), 128'(latOf(d)));
                        seenValid[d] = 1'b1;
                    end
                    checkOutput($sformatf("d%0d_result", d), stateOutA[d], expVal[d]);
                    if (out_ready) pending[d] = 1'b0;
                end
                if (in_valid && inReadyA[d]) begin
                    if (streamMode && streamPrev[d]) begin
                        checkOutput($sformatf("d%0d_issue_spacing", d), 128'(cyc + 1 - acceptEdge[d]), 128'(latOf(d) + 2));
                    end
                    expVal[d]      = invModel(state_in);
                    acceptEdge[d]  = cyc + 1;
                    pending[d]     = 1'b1;
                    seenValid[d]   = 1'b0;
                    streamPrev[d]  = streamMode;
                    acceptCount[d] = acceptCount[d] + 1;
                end
            end
        end
    end

    // Directed scenario sequence followed by random streaming and the round-trip identity check.
    initial begin
        logic [127:0] held [NDUT];
        logic [127:0] vec;
        logic [127:0] orig;
        int base;
        int n;

        for (int d = 0; d < NDUT; d++) acceptCount[d] = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        state_in  = 'x;
        reset_n   = 1'b1;
        #2;
        reset_n   = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("d%0d_reset_in_ready", d),  128'(inReadyA[d]),  128'(1));
            checkOutput($sformatf("d%0d_reset_out_valid", d), 128'(outValidA[d]), 128'(0));
            checkOutput($sformatf("d%0d_reset_state_out", d), stateOutA[d], 128'(0));
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        checkOutput("model_col_8e4da1bc", 128'(mixCol(32'h8e4da1bc, 32'h0e0b0d09)), 128'(32'hdb135345));
        checkOutput("model_col_9fdc589d", 128'(mixCol(32'h9fdc589d, 32'h0e0b0d09)), 128'(32'hf20a225c));
        checkOutput("model_col_d5d5d7d6", 128'(mixCol(32'hd5d5d7d6, 32'h0e0b0d09)), 128'(32'hd4d4d4d5));
        checkOutput("model_col_4d7ebdf8", 128'(mixCol(32'h4d7ebdf8, 32'h0e0b0d09)), 128'(32'h2d26314c));
        checkOutput("model_fwd_db135345", 128'(mixCol(32'hdb135345, 32'h02030101)), 128'(32'h8e4da1bc));

        // Standard column vector.
        waitIdle(20);
        applyStimulus({32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6});
        waitIdle(20);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("d%0d_vec1", d), stateOutA[d],
                        {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6});
        end

        // Mixed vector.
        applyStimulus({32'hd5d5d7d6, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'hd5d5d7d6});
        waitIdle(20);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("d%0d_vec2", d), stateOutA[d],
                        {32'hd4d4d4d5, 32'h2d26314c, 32'h2d26314c, 32'hd4d4d4d5});
        end

        // Backpressure: result must sit still while upstream keeps offering.
        out_ready = 1'b0;
        applyStimulus({32'h01010101, 32'hc6c6c6c6, 32'h8e4da1bc, 32'hd5d5d7d6});
        n = 0;
        while (!(outValidA[0] && outValidA[1] && outValidA[2]) && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("d%0d_bp_valid", d), 128'(outValidA[d]), 128'(1));
            checkOutput($sformatf("d%0d_bp_result", d), stateOutA[d],
                        {32'h01010101, 32'hc6c6c6c6, 32'hdb135345, 32'hd4d4d4d5});
            held[d] = stateOutA[d];
        end
        in_valid = 1'b1;
        state_in = {4{32'h9fdc589d}};
        repeat (10) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                checkOutput($sformatf("d%0d_bp_hold_valid", d), 128'(outValidA[d]), 128'(1));
                checkOutput($sformatf("d%0d_bp_hold_ready", d), 128'(inReadyA[d]), 128'(0));
                checkOutput($sformatf("d%0d_bp_hold_state", d), stateOutA[d], held[d]);
            end
        end
        in_valid  = 1'b0;
        state_in  = 'x;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("d%0d_bp_release_valid", d), 128'(outValidA[d]), 128'(0));
            checkOutput($sformatf("d%0d_bp_release_ready", d), 128'(inReadyA[d]), 128'(1));
        end

        // Reset two edges into the computation, then a fresh vector.
        waitIdle(20);
        applyStimulus({32'hc6c6c6c6, 32'h01010101, 32'h9fdc589d, 32'h8e4da1bc});
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("d%0d_midrst_valid", d), 128'(outValidA[d]), 128'(0));
            checkOutput($sformatf("d%0d_midrst_ready", d), 128'(inReadyA[d]), 128'(1));
            checkOutput($sformatf("d%0d_midrst_state", d), stateOutA[d], 128'(0));
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        waitIdle(20);
        applyStimulus({32'hd5d5d7d6, 32'h4d7ebdf8, 32'h8e4da1bc, 32'h9fdc589d});
        waitIdle(20);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("d%0d_post_reset", d), stateOutA[d],
                        {32'hd4d4d4d5, 32'h2d26314c, 32'hdb135345, 32'hf20a225c});
        end

        // Streaming random states with the consumer always ready.
        base = acceptCount[0];
        streamMode = 1'b1;
        in_valid   = 1'b1;
        n = 0;
        while ((acceptCount[0] - base) < 100 && n < 1000) begin
            state_in = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            n++;
        end
        in_valid   = 1'b0;
        streamMode = 1'b0;
        state_in   = 'x;
        checkOutput("stream_accepts", 128'((acceptCount[0] - base) >= 100), 128'(1));
        waitIdle(20);

        // Forward MixColumns followed by this block must give back the original.
        for (int t = 0; t < 3; t++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            vec  = fwdModel(orig);
            applyStimulus(vec);
            waitIdle(20);
            for (int d = 0; d < NDUT; d++) begin
                checkOutput($sformatf("d%0d_identity_%0d", d, t), stateOutA[d], orig);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
